mips_cpu_muldiv: RTL and testbench

Multi-cycle, parametrised multiply/divide unit with architectural HI/LO registers, sitting beside the execute-stage ALU. It replaces the single-cycle combinational `*`, `/` and `%` path with a shift-add multiplier and a restoring divider, and adds a start/busy/done handshake so the core can stall on HI/LO dependencies. It also owns MTHI/MTLO writes and the MFHI/MFLO read data.

---
 rtl/mips_cpu_muldiv_if.sv | 39 +++
 rtl/mips_cpu_muldiv.sv | 177 +++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_muldiv_if
//  Description : Request/response bundle between the execute stage and the
//                multiply/divide unit.
//                master (core side) drives start/op/a/b and the MTHI/MTLO
//                write port; slave (mips_cpu_muldiv) returns busy/done,
//                div_zero and the architectural HI/LO values.
//  Ports       : start, op[1:0], a, b, hi_wr_en, lo_wr_en, wr_data  (core -> unit)
//                busy, done, div_zero, hi, lo                        (unit -> core)
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr_en;
    logic             lo_wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr_en, lo_wr_en, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr_en, lo_wr_en, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_muldiv
//  Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
//                Shift-add multiplier and restoring divider working on operand
//                magnitudes; signs are applied in a final FIX cycle.
//                Optional single-cycle array product for MULT/MULTU.
//  Ports       : clk, reset (sync, active high)
//                bus (mips_cpu_muldiv_if.slave): start/op/a/b request,
//                hi_wr_en/lo_wr_en/wr_data (MTHI/MTLO), busy, done,
//                div_zero, hi, lo
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_muldiv #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mips_cpu_muldiv_if.slave  bus
);
    localparam int              c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]       r_state, w_next_state;
    logic [c_CW-1:0]  r_count;
    logic             r_is_div, r_neg_q, r_neg_r, r_b_zero;
    // Multiply: {r_hi_work, r_lo_work} is the product accumulator, r_lo_work
    // starts as the multiplier and is shifted out LSB first.
    // Divide: r_hi_work is the partial remainder, r_lo_work starts as the
    // dividend and fills with quotient bits from the right.
    logic [WIDTH-1:0] r_hi_work, r_lo_work, r_opnd;
    logic             r_busy, r_done, r_div_zero;
    logic [WIDTH-1:0] r_hi, r_lo;

    // ---------------- acceptance and operand magnitudes ----------------
    logic             w_accept, w_signed, w_a_neg, w_b_neg, w_is_mul;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_accept = bus.start && (r_state == c_IDLE);
    assign w_signed = ~bus.op[0];
    assign w_is_mul = ~bus.op[1];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    logic [2*WIDTH-1:0] w_fast_prod;
    generate
        if (FAST_MUL) begin : g_fast_mul
            assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     w_add, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_rem_fix, w_quo_fix;

    assign w_add   = r_lo_work[0] ? ({1'b0, r_hi_work} + {1'b0, r_opnd}) : {1'b0, r_hi_work};
    assign w_shift = {r_hi_work, r_lo_work[WIDTH-1]};
    // Top bit of the (WIDTH+1)-bit difference is the borrow: set means the
    // divisor did not fit and the shifted remainder is restored.
    assign w_diff  = w_shift - {1'b0, r_opnd};

    assign w_prod     = {r_hi_work, r_lo_work};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    // With b=0 the remainder ends up equal to |a|, so the sign fix restores
    // a exactly; only the quotient needs forcing to all ones.
    assign w_rem_fix  = r_neg_r ? -r_hi_work : r_hi_work;
    assign w_quo_fix  = r_b_zero ? '1 : (r_neg_q ? -r_lo_work : r_lo_work);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_next_state = (FAST_MUL && w_is_mul) ? c_FIX : c_CALC;
            c_CALC: if (r_count == c_LAST) w_next_state = c_FIX;
            c_FIX:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- datapath and architectural registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_hi_work  <= '0;
            r_lo_work  <= '0;
            r_opnd     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next_state != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_is_div   <= bus.op[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_b_zero   <= bus.op[1] && (bus.b == '0);
                        r_div_zero <= 1'b0;
                        r_count    <= '0;
                        if (bus.op[1]) begin
                            r_hi_work <= '0;
                            r_lo_work <= w_a_mag;
                            r_opnd    <= w_b_mag;
                        end else if (FAST_MUL) begin
                            {r_hi_work, r_lo_work} <= w_fast_prod;
                            r_opnd                 <= w_a_mag;
                        end else begin
                            r_hi_work <= '0;
                            r_lo_work <= w_b_mag;
                            r_opnd    <= w_a_mag;
                        end
                    end else begin
                        // MTHI/MTLO only land when no operation is starting.
                        if (bus.hi_wr_en) r_hi <= bus.wr_data;
                        if (bus.lo_wr_en) r_lo <= bus.wr_data;
                    end
                end
                c_CALC: begin
                    r_count <= r_count + c_ONE;
                    if (r_is_div) begin
                        if (!w_diff[WIDTH]) begin
                            r_hi_work <= w_diff[WIDTH-1:0];
                            r_lo_work <= {r_lo_work[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi_work <= w_shift[WIDTH-1:0];
                            r_lo_work <= {r_lo_work[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {r_hi_work, r_lo_work} <= {w_add, r_lo_work[WIDTH-1:1]};
                    end
                end
                c_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi       <= w_rem_fix;
                        r_lo       <= w_quo_fix;
                        r_div_zero <= r_b_zero;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_muldiv
//  Description : Scoreboard bench for mips_cpu_muldiv. Expected HI/LO results
//                come from plain 64-bit arithmetic; a negedge monitor pops
//                and compares whenever done pulses. A second instance with
//                FAST_MUL=1 covers the two-cycle multiply path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_muldiv;
    localparam int c_W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic [31:0] m_hi, m_lo;

    mips_cpu_muldiv_if #(.WIDTH(c_W)) bus ();
    mips_cpu_muldiv_if #(.WIDTH(c_W)) bus_f ();

    mips_cpu_muldiv #(.WIDTH(c_W), .FAST_MUL(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    mips_cpu_muldiv #(.WIDTH(c_W), .FAST_MUL(1'b1)) dut_fast (
        .clk(clk), .reset(reset), .bus(bus_f.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: architectural results from plain integer arithmetic.
    function automatic exp_t ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          sx, sy;
        e.dz = 1'b0; e.cyc = 0; e.hi = '0; e.lo = '0;
        sx = x; sy = y;
        case (o)
            2'd0: begin p = longint'(sx) * longint'(sy); {e.hi, e.lo} = p; end
            2'd1: begin u = {32'd0, x} * {32'd0, y}; {e.hi, e.lo} = u; end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else if (o == 2'd2) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        e.lo = x; e.hi = 32'd0;
                    end else begin
                        e.lo = sx / sy; e.hi = sx % sy;
                    end
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = ref_op(o, x, y);
        e.cyc = cyc + c_W + 2;
        q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Called and returns just after a negedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin failures++; checks++; $display("FAIL issue_wait_busy actual=busy required=idle"); end
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        if (push) push_exp(o, x, y);
        @(negedge clk);
        bus.start = 1'b0;
        check("accept_busy", {63'd0, bus.busy}, 64'd1);
        check("accept_dz_clear", {63'd0, bus.div_zero}, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || q.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin failures++; checks++; $display("FAIL wait_idle_timeout actual=busy required=idle"); end
    endtask

    task automatic issue_fast(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = ref_op(o, x, y);
        bus_f.start = 1'b1; bus_f.op = o; bus_f.a = x; bus_f.b = y;
        @(negedge clk);
        bus_f.start = 1'b0;
        check("fast_busy1", {63'd0, bus_f.busy}, 64'd1);
        check("fast_done0", {63'd0, bus_f.done}, 64'd0);
        @(negedge clk);
        check("fast_done1", {63'd0, bus_f.done}, 64'd1);
        check("fast_busy0", {63'd0, bus_f.busy}, 64'd0);
        check("fast_hilo", {bus_f.hi, bus_f.lo}, {e.hi, e.lo});
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() != 0 && cyc > q[0].cyc) begin
                checks++; failures++;
                $display("FAIL done_missing actual=no_done required=done_at_cycle_%0d", q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_hi", {32'd0, bus.hi}, {32'd0, e.hi});
                    check("sb_lo", {32'd0, bus.lo}, {32'd0, e.lo});
                    check("sb_div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
                    check("sb_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic [31:0] prev_lo, ra, rb;
        logic [1:0]  ro;
        int          n;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_wr_en = 0; bus.lo_wr_en = 0; bus.wr_data = 0;
        bus_f.start = 0; bus_f.op = 0; bus_f.a = 0; bus_f.b = 0;
        bus_f.hi_wr_en = 0; bus_f.lo_wr_en = 0; bus_f.wr_data = 0;
        m_hi = 0; m_lo = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dz", {63'd0, bus.div_zero}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(2'd0, 32'hFFFF_FFF9, 32'd3, 1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1);
        issue(2'd3, 32'd7, 32'd2, 1);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(2'd3, 32'h0000_1234, 32'd0, 1);
        wait_idle();
        check("dz_set", {63'd0, bus.div_zero}, 64'd1);
        check("dz_hilo", {bus.hi, bus.lo}, {32'h0000_1234, 32'hFFFF_FFFF});

        // MTHI while busy is dropped; issue() also checks div_zero clears
        issue(2'd1, 32'd3, 32'd5, 1);
        repeat (5) @(negedge clk);
        bus.hi_wr_en = 1'b1; bus.wr_data = 32'hAAAA_0000;
        @(negedge clk);
        bus.hi_wr_en = 1'b0;
        wait_idle();
        check("mthi_busy_drop", {32'd0, bus.hi}, {32'd0, m_hi});

        // MTLO idle, then both together
        bus.lo_wr_en = 1'b1; bus.wr_data = 32'h0000_0055;
        @(negedge clk);
        bus.lo_wr_en = 1'b0;
        check("mtlo_idle", {32'd0, bus.lo}, 64'h55);
        check("mtlo_hi_kept", {32'd0, bus.hi}, {32'd0, m_hi});
        bus.hi_wr_en = 1'b1; bus.lo_wr_en = 1'b1; bus.wr_data = 32'h1357_9BDF;
        @(negedge clk);
        bus.hi_wr_en = 1'b0; bus.lo_wr_en = 1'b0;
        check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h1357_9BDF, 32'h1357_9BDF});

        // start with MTLO in the same cycle: start wins
        prev_lo = bus.lo;
        bus.lo_wr_en = 1'b1; bus.wr_data = 32'h0000_0077;
        issue(2'd1, 32'd2, 32'd2, 1);
        bus.lo_wr_en = 1'b0;
        check("start_mtlo_drop", {32'd0, bus.lo}, {32'd0, prev_lo});
        wait_idle();

        // Randomised operations, issued back to back
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb, 1);
        end
        wait_idle();
        check("rand_final_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        // Reset in the middle of a divide
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (c_W + 6) @(negedge clk);
        check("midrst_hilo_later", {bus.hi, bus.lo}, 64'd0);

        // Back-to-back with start held high
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd3; bus.b = 32'd4;
        push_exp(2'd1, 32'd3, 32'd4);
        @(negedge clk);
        bus.a = 32'd5; bus.b = 32'd6;
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        check("b2b_done_cycle", {63'd0, bus.done}, 64'd1);
        push_exp(2'd1, 32'd5, 32'd6);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_second_busy", {63'd0, bus.busy}, 64'd1);
        wait_idle();
        check("b2b_lo", {32'd0, bus.lo}, 64'd30);

        // FAST_MUL instance
        issue_fast(2'd0, 32'hFFFF_FFF9, 32'd3);
        for (int i = 0; i < 6; i++) begin
            issue_fast(2'($urandom_range(0, 1)), $urandom, $urandom);
        end

        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
